// File: rtl/dcache_controller_if.sv
// CPU load/store and memory-side bus of the data cache controller.
// The master modport is the controller's view (it initiates memory
// accesses), the slave modport is the CPU/memory environment's view.
interface dcache_controller_if #(
    parameter int unsigned ADDR_W = 11
);
    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read misses fill a 4-word aligned block in ascending word order; the
// held load then hits on return to IDLE. Stores take two cycles and
// update the line only when it already holds the address.
// Optional feature macro: CACHE_STATS_EN (read hit/miss counters).
module dcache_controller #(
    parameter int unsigned NUM_BLOCKS  = 16,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 11
) (
    input  logic               clock,
    input  logic               reset,
    dcache_controller_if.master bus,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
);
    localparam int unsigned INDEX_W = $clog2(NUM_BLOCKS);
    localparam int unsigned TAG_W   = ADDR_W - 2 - INDEX_W;
    localparam int unsigned LAT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e             state_q;
    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [NUM_BLOCKS];
    logic [31:0]        data_q [NUM_BLOCKS][4];

    logic [TAG_W-1:0]   fill_tag_q;
    logic [INDEX_W-1:0] fill_idx_q;
    logic [1:0]         word_idx_q;
    logic [LAT_W-1:0]   lat_cnt_q;

    logic               mem_read_q;
    logic               mem_write_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [31:0]        mem_wdata_q;
    logic               wr_ready_q;

    logic [1:0]         req_off;
    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               line_hit;
    logic               rd_hit;
    logic               capture;
    logic               fill_done;

    // Address decode, lookup and fill-capture timing
    always_comb begin
        req_off   = bus.cpu_addr[1:0];
        req_idx   = bus.cpu_addr[INDEX_W+1:2];
        req_tag   = bus.cpu_addr[ADDR_W-1:INDEX_W+2];
        line_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        rd_hit    = (state_q == IDLE) && bus.cpu_read && !bus.cpu_write && line_hit;
        capture   = (state_q == FILL) && (lat_cnt_q == LAT_W'(MEM_LATENCY - 1));
        fill_done = capture && (word_idx_q == 2'd3);
    end

    // Controller FSM with registered memory strobes, address and data
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            fill_tag_q  <= '0;
            fill_idx_q  <= '0;
            word_idx_q  <= '0;
            lat_cnt_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wr_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cpu_write) begin
                        state_q     <= WRITE;
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= bus.cpu_addr;
                        mem_wdata_q <= bus.cpu_wdata;
                        wr_ready_q  <= 1'b1;
                    end else if (bus.cpu_read && !line_hit) begin
                        state_q    <= FILL;
                        fill_tag_q <= req_tag;
                        fill_idx_q <= req_idx;
                        word_idx_q <= '0;
                        lat_cnt_q  <= '0;
                        mem_read_q <= 1'b1;
                        mem_addr_q <= {req_tag, req_idx, 2'b00};
                    end
                end
                FILL: begin
                    if (capture) begin
                        lat_cnt_q <= '0;
                        if (fill_done) begin
                            // Line becomes valid only once all four words are in.
                            valid_q[fill_idx_q] <= 1'b1;
                            tag_q[fill_idx_q]   <= fill_tag_q;
                            state_q             <= IDLE;
                            word_idx_q          <= '0;
                            mem_read_q          <= 1'b0;
                            mem_addr_q          <= '0;
                        end else begin
                            word_idx_q <= word_idx_q + 2'd1;
                            mem_addr_q <= {fill_tag_q, fill_idx_q, word_idx_q + 2'd1};
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q + LAT_W'(1);
                    end
                end
                WRITE: begin
                    state_q     <= IDLE;
                    mem_write_q <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    wr_ready_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Data array: fill captures and write-hit updates (contents not reset)
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (capture) begin
                data_q[fill_idx_q][word_idx_q] <= bus.mem_rdata;
            end else if ((state_q == WRITE) && line_hit) begin
                data_q[req_idx][req_off] <= bus.cpu_wdata;
            end
        end
    end

    assign bus.cpu_ready = rd_hit || wr_ready_q;
    assign bus.cpu_rdata = rd_hit ? data_q[req_idx][req_off] : '0;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
    logic        replay_q;
    logic [15:0] hit_q;
    logic [15:0] miss_q;

    // Saturating load statistics; the post-fill replay hit is not recounted
    always_ff @(posedge clock) begin
        if (reset) begin
            replay_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            replay_q <= fill_done;
            if (rd_hit && !replay_q && (hit_q != '1)) begin
                hit_q <= hit_q + 16'd1;
            end
            if ((state_q == IDLE) && bus.cpu_read && !bus.cpu_write && !line_hit
                && (miss_q != '1)) begin
                miss_q <= miss_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: the driver predicts each access
// from a transparent-memory cache model and queues the expectation; the
// monitor checks completions and fill addresses as the DUT presents them.
module tb_dcache_controller;
    localparam int unsigned NB  = 16;
    localparam int unsigned LAT = 1;
    localparam int unsigned AW  = 11;

    typedef struct {
        bit          is_read;
        logic [10:0] addr;
        logic [31:0] data;
        int unsigned done;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    dcache_controller_if #(.ADDR_W(AW)) bus ();

    dcache_controller #(
        .NUM_BLOCKS (NB),
        .MEM_LATENCY(LAT),
        .ADDR_W     (AW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    // Memory device seen by the DUT
    logic [31:0] mem [2048];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clock) if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;

    // Reference model: memory image plus which block each line holds
    logic [31:0] ref_mem [2048];
    bit          ref_valid [NB];
    int unsigned ref_block [NB];
    int unsigned ref_hits, ref_misses;

    exp_t        exp_q[$];
    logic [10:0] fill_q[$];
    int unsigned cyc = 0;
    bit          mon_en = 1'b0;
    int          nvec = 0;
    int          nmis = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows activity
    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.mem_read && bus.mem_write)
                chk("strobe_exclusive", 32'd1, 32'd0);
            if (!bus.mem_read && !bus.mem_write && (bus.mem_addr != '0 || bus.mem_wdata != '0))
                chk("idle_bus_zero", {bus.mem_addr, 21'd0} | bus.mem_wdata, 32'd0);
            if (bus.mem_read) begin
                if (fill_q.size() == 0) begin
                    chk("unexpected_mem_read", {21'd0, bus.mem_addr}, 32'hFFFFFFFF);
                end else begin
                    logic [10:0] fa;
                    fa = fill_q.pop_front();
                    chk("fill_addr", {21'd0, bus.mem_addr}, {21'd0, fa});
                end
            end
            if (bus.cpu_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.done);
                    if (e.is_read) begin
                        chk("rdata", bus.cpu_rdata, e.data);
                    end else begin
                        chk("wr_strobe", {31'd0, bus.mem_write}, 32'd1);
                        chk("wr_addr", {21'd0, bus.mem_addr}, {21'd0, e.addr});
                        chk("wr_data", bus.mem_wdata, e.data);
                    end
                end
            end
        end
    end

    task automatic wait_done(input string nm);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.cpu_ready && n < 40);
        if (!bus.cpu_ready) begin
            nmis++;
            $display("FAIL %s_timeout: got no cpu_ready expected cpu_ready within 40 cycles", nm);
            $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
            $fatal(1, "timeout");
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_read(input int unsigned a);
        exp_t        e;
        int unsigned blk, idx;
        blk = a / 4;
        idx = blk % NB;
        e.is_read = 1'b1;
        e.addr    = 11'(a);
        e.data    = ref_mem[a];
        if (ref_valid[idx] && ref_block[idx] == blk) begin
            e.done = cyc;
            ref_hits++;
        end else begin
            e.done = cyc + 4 * LAT + 1;
            for (int unsigned w = 0; w < 4; w++)
                for (int unsigned l = 0; l < LAT; l++)
                    fill_q.push_back(11'(blk * 4 + w));
            ref_valid[idx] = 1'b1;
            ref_block[idx] = blk;
            ref_misses++;
        end
        exp_q.push_back(e);
        bus.cpu_addr = 11'(a);
        bus.cpu_read = 1'b1;
        wait_done("read");
        bus.cpu_read = 1'b0;
    endtask

    task automatic do_write(input int unsigned a, input logic [31:0] d);
        exp_t e;
        e.is_read  = 1'b0;
        e.addr     = 11'(a);
        e.data     = d;
        e.done     = cyc + 1;
        ref_mem[a] = d;
        exp_q.push_back(e);
        bus.cpu_addr  = 11'(a);
        bus.cpu_wdata = d;
        bus.cpu_write = 1'b1;
        wait_done("write");
        bus.cpu_write = 1'b0;
    endtask

    task automatic check_stats(input string nm);
`ifdef CACHE_STATS_EN
        chk({nm, "_hits"},   {16'd0, hit_count},  ref_hits);
        chk({nm, "_misses"}, {16'd0, miss_count}, ref_misses);
`else
        chk({nm, "_hits"},   {16'd0, hit_count},  32'd0);
        chk({nm, "_misses"}, {16'd0, miss_count}, 32'd0);
`endif
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_ready"},  {31'd0, bus.cpu_ready}, 32'd0);
        chk({nm, "_rdata"},  bus.cpu_rdata, 32'd0);
        chk({nm, "_mrd"},    {31'd0, bus.mem_read}, 32'd0);
        chk({nm, "_mwr"},    {31'd0, bus.mem_write}, 32'd0);
        chk({nm, "_maddr"},  {21'd0, bus.mem_addr}, 32'd0);
        chk({nm, "_mwdata"}, bus.mem_wdata, 32'd0);
        chk({nm, "_hitcnt"}, {16'd0, hit_count}, 32'd0);
        chk({nm, "_misscnt"}, {16'd0, miss_count}, 32'd0);
    endtask

    task automatic model_reset();
        for (int unsigned i = 0; i < NB; i++) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
        exp_q.delete();
        fill_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1 ms");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        for (int i = 0; i < 2048; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[1024] = 200; mem[1025] = 7; mem[1026] = 200; mem[1027] = 9;
        for (int i = 1024; i < 1028; i++) ref_mem[i] = mem[i];
        model_reset();

        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("reset");
        @(posedge clock);
        #1 mon_en = 1'b1;

        do_read(1024);              check_stats("s1");
        do_read(1025);              check_stats("s2");
        do_write(1026, 32'd55);
        do_read(1026);              check_stats("s3");
        do_read(1088);
        do_read(1024);              check_stats("s4");
        do_write(1100, 32'h1234_5678);
        do_read(1100);              check_stats("s5");

        // Reset while the fill of 1088 is on its third word
        mon_en = 1'b0;
        bus.cpu_addr = 11'd1088;
        bus.cpu_read = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("midfill_mrd", {31'd0, bus.mem_read}, 32'd1);
        chk("midfill_addr", {21'd0, bus.mem_addr}, 32'd1090);
        reset = 1'b1;
        bus.cpu_read = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("midreset");
        model_reset();
        @(posedge clock);
        #1 mon_en = 1'b1;
        do_read(1024);              check_stats("s6");

        for (int k = 0; k < 300; k++) begin
            int unsigned a;
            a = (16 + $urandom_range(0, 2)) * 64 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
            if ($urandom_range(0, 99) < 30) do_write(a, $urandom);
            else                            do_read(a);
        end
        check_stats("random");

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        chk("fill_q_drained", fill_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Direct-mapped, write-through, no-write-allocate data cache controller. It sits between the CPU load/store stage and the word-addressed data memory, and acts as the initiator on the memory-side interface. Read misses fill a 4-word aligned block, one word at a time, under a fixed memory latency. The CPU is stalled via cpu_ready until the access completes.

Parameters:
NUM_BLOCKS, 16, number of cache lines; power of two, at least 2; INDEX_W = log2(NUM_BLOCKS)
MEM_LATENCY, 1, cycles each memory word read is held before capture; at least 1
ADDR_W, 11, word address width; TAG_W = ADDR_W - 2 - INDEX_W

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high
cpu_read  in  1  load request; held until cpu_ready
cpu_write  in  1  store request; held until cpu_ready
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data; valid when cpu_ready && cpu_read
cpu_ready  out  1  access completes this cycle
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe; memory writes at posedge
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data; combinational from mem_addr
hit_count  out  16  read hits (optional feature)
miss_count  out  16  read misses (optional feature)

Behaviour:
- Address split: offset = addr[1:0]; index = addr[INDEX_W+1:2]; tag = addr[ADDR_W-1:INDEX_W+2].
- Storage per line: valid bit, tag, 4 x 32-bit words. The data array is not reset.
- On reset: state IDLE, all valid bits 0, fill counters 0, all outputs 0, counters 0.
- Reset wins over any in-flight fill or write. No partial line ever becomes valid.
- States: IDLE, FILL, WRITE.
- IDLE, cpu_write=1: cpu_write takes priority if cpu_read is also high. Go to WRITE; cpu_ready=0.
- IDLE, cpu_read=1, hit (valid && tag match): cpu_ready=1 combinationally in the same cycle; cpu_rdata = line word[offset]. No memory activity.
- IDLE, cpu_read=1, miss: cpu_ready=0. Go to FILL with word_idx=0 and lat_cnt=0.
- IDLE, no request: all strobes 0.
- FILL:
  - mem_read=1; mem_addr = {tag, index, word_idx}, ascending 0..3 regardless of requested offset.
  - lat_cnt counts up to MEM_LATENCY-1. On that cycle, capture mem_rdata into word[word_idx] and advance word_idx.
  - After capturing word 3: set valid, write tag, return to IDLE.
  - The held request then hits in IDLE.
  - Total read-miss latency = 4*MEM_LATENCY + 2 cycles from request to cpu_ready.
- WRITE: one cycle.
  - mem_write=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, cpu_ready=1.
  - If the line hits, update word[offset] at the same edge; a miss does not allocate.
  - Return to IDLE. A store costs 2 cycles.
- CPU inputs must be stable while cpu_ready=0. Changes during FILL are undefined use; the fill still completes for the latched address.
- mem_read and mem_write are never both 1. mem_addr and mem_wdata are 0 when no strobe is active.

Optional Feature:
CACHE_STATS_EN defined:
- hit_count increments on an IDLE read hit that is not the replay following a FILL.
- miss_count increments on entry to FILL.
- Both saturate at 16'hFFFF and clear on reset.
- Each load counts exactly once.
CACHE_STATS_EN undefined: hit_count and miss_count are tied to 0 and no counter logic is synthesized.

Test Plan:
Setup for all scenarios: NUM_BLOCKS=16, MEM_LATENCY=1; memory preloaded with 1024=200, 1025=7, 1026=200, 1027=9.
1. Reset, then read 1024 -> mem_read with mem_addr 1024,1025,1026,1027 on consecutive cycles. cpu_ready on cycle 6 with cpu_rdata=200. miss_count=1.
2. Following read of 1025 -> cpu_ready in the same cycle, cpu_rdata=7, mem_read stays 0. hit_count=1.
3. Write 55 to 1026 -> next cycle mem_write=1, mem_addr=1026, mem_wdata=55, cpu_ready=1. A following read of 1026 hits and returns 55.
4. Read 1088 (index 0, tag differs from 1024) -> miss and refill of 1088..1091. A subsequent read of 1024 misses again; miss_count=3.
5. Write to uncached 1100 -> mem_write only, line stays invalid. A following read of 1100 misses and fills 1100..1103.
6. Assert reset during FILL at word_idx=2 -> next cycle IDLE, all strobes 0, counters 0. A read of 1024 misses and refills all 4 words.
